mul_seq: RTL and testbench
==========================

# mul_seq

Sequential 32x32 multiplier producing the low 32 bits of the product by shift-and-add, one partial product per cycle. The block has no internal adder. It drives the operand inputs of the shared 32-bit ripple adder (`adder32bit`) and registers that adder's sum each cycle. It sits between the execute-stage operand registers and the ALU result mux, and serves the MUL instruction. The low 32 bits are identical for signed and unsigned two's-complement operands, so there is no signed mode.

## Interface
Parameters: none (width fixed at 32).

- `clk` in 1 — sole clock; all state updates on the rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `in_valid` in 1 — operands `op_a`/`op_b` are valid.
- `in_ready` out 1 — block can accept operands; high only in IDLE.
- `op_a` in 32 — multiplicand.
- `op_b` in 32 — multiplier.
- `abort` in 1 — synchronous cancel; returns the block to IDLE.
- `out_valid` out 1 — `result` is valid; high only in DONE.
- `out_ready` in 1 — consumer accepts `result`.
- `result` out 32 — low 32 bits of `op_a*op_b`.
- `adder_a` out 32 — to adder input A.
- `adder_b` out 32 — to adder input B.
- `adder_sum` in 32 — from adder result; combinational return.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, DONE}.
  - `acc[31:0]`, `mcand[31:0]`, `mplier[31:0]`.
- Reset (`reset_n`=0, asynchronous) values:
  - `state`=IDLE; `acc`, `mcand`, `mplier` = 0.
  - Outputs under reset: `in_ready`=1, `out_valid`=0, `result`=0, `adder_a`=0, `adder_b`=0.
- Adder drive (combinational):
  - `adder_a` = `acc` in all states.
  - `adder_b` = (state==RUN && `mplier[0]`) ? `mcand` : 0.
- `result` = `acc` in all states. It is only meaningful while `out_valid`=1.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`=1 (and `abort`=0): `mcand`←`op_a`, `mplier`←`op_b`, `acc`←0, go to RUN.
- RUN, each cycle:
  - `acc`←`adder_sum`; `mcand`←`mcand`<<1; `mplier`←`mplier`>>1.
  - If (`mplier`>>1)==0, go to DONE; otherwise stay in RUN.
- DONE:
  - `out_valid`=1; `acc` is held.
  - On `out_ready`=1, go to IDLE.
- Arithmetic: all values are modulo 2^32. Bits shifted out of `mcand` are discarded. The adder has no carry-out, and none is needed.
- `abort`=1 in any state: next state is IDLE and `acc`←0. It takes priority over `in_valid` and `out_ready`. A result that has not yet been accepted is dropped.
- No overlap: a new operation is accepted only after the previous result has been taken.

## Timing
- Handshake:
  - Input transfer happens on the edge where `in_valid`&&`in_ready`.
  - Output transfer happens on the edge where `out_valid`&&`out_ready`.
- RUN length N = bit length of `op_b`, i.e. index of the highest set bit + 1. For `op_b`=0, N=1. Range is 1..32.
- Latency:
  - Input accepted on edge t: RUN during cycles t+1..t+N.
  - `out_valid` rises after edge t+N and stays high until accepted.
- Backpressure: with `out_ready`=0, `out_valid` and `result` stay constant indefinitely.
- Minimum issue interval is N+2 cycles: N RUN cycles, one DONE cycle with `out_ready`=1, and one IDLE cycle for the accept.
- The adder is combinational. `adder_sum` must settle within one `clk` period of the `acc`/`mcand` update.
- Reset asserted mid-RUN or in DONE: returns immediately to the reset values above, with no output transfer.
- Inputs `op_a`/`op_b` are sampled only on the accept edge. Later changes to them have no effect.

## Test plan
- `op_a`=6, `op_b`=7 accepted on edge 0 → RUN for 3 cycles; `out_valid` high after edge 3; `result`=42.
- `op_a`=`op_b`=0xFFFFFFFF → N=32; `result`=0x00000001; `out_valid` rises after edge 32.
- `op_a`=0x12345678, `op_b`=0 → N=1; `result`=0; `adder_b`=0 throughout RUN.
- `op_a`=3, `op_b`=5 with `out_ready` held low for 5 cycles after `out_valid` rises → `result` stays 15 and `out_valid` stays high; `in_ready` stays 0 until the cycle after `out_ready` pulses.
- `op_b`=0x80000000, `abort` pulsed in the 10th RUN cycle → IDLE on the next cycle with `in_ready`=1 and no `out_valid`; a new request `op_a`=4, `op_b`=4 then returns 16.
- `reset_n` driven low asynchronously mid-RUN → `out_valid`=0, `in_ready`=1, `result`=0 immediately; after release, `op_a`=0xFFFF, `op_b`=0x10001 returns 0xFFFFFFFF.

Source files
------------

// File: rtl/mul_seq.sv
// mul_seq: 32x32 shift-and-add multiplier, low 32 bits of the product.
// Drives the shared adder (adder_a/adder_b) and registers adder_sum each RUN cycle.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   in_valid/in_ready     operand handshake (op_a multiplicand, op_b multiplier)
//   abort                 synchronous cancel back to IDLE
//   out_valid/out_ready   result handshake, result = low 32 bits of op_a*op_b
//   adder_a/adder_b       operands to the external adder
//   adder_sum             combinational sum returned by the adder
module mul_seq (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        abort,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [31:0] adder_a,
   output logic [31:0] adder_b,
   input  logic [31:0] adder_sum
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] mcand_q, mcand_d;
   logic [31:0] mplier_q, mplier_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      adder_b   = '0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mcand_d  = op_a;
               mplier_d = op_b;
               acc_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (mplier_q[0])
               adder_b = mcand_q;
            acc_d    = adder_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            // last RUN cycle once no set multiplier bits remain above bit 0
            if (mplier_q[31:1] == 31'd0)
               state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // cancel wins over any handshake and drops a pending result
      if (abort) begin
         state_d = IDLE;
         acc_d   = '0;
      end
   end

   assign adder_a = acc_q;
   assign result  = acc_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: randomized self-checking bench for mul_seq.
// Reference: low 32 bits of a*b, RUN length = bit length of op_b.
module tb_mul_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        abort;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [31:0] adder_a;
   logic [31:0] adder_b;
   logic [31:0] adder_sum;

   int checks = 0;
   int errors = 0;

   mul_seq dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .adder_a   (adder_a),
      .adder_b   (adder_b),
      .adder_sum (adder_sum)
   );

   // the shared ripple adder, modelled behaviourally
   assign adder_sum = adder_a + adder_b;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int bitlen(input logic [31:0] v);
      int n;
      n = 1;
      for (int i = 0; i < 32; i++)
         if (v[i]) n = i + 1;
      return n;
   endfunction

   // start an operation: assumes called #1 after a rising edge
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      op_a     = $urandom;
      op_b     = $urandom;
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input int hold);
      logic [31:0] exp;
      int          n;
      int          cnt;
      exp = a * b;
      n   = bitlen(b);
      issue(a, b);
      // first RUN cycle: accumulator cleared, first partial product
      chk("adder_a_first", {32'd0, adder_a}, 64'd0);
      chk("adder_b_first", {32'd0, adder_b}, {32'd0, b[0] ? a : 32'd0});
      cnt = 0;
      do begin
         @(posedge clk);
         #1;
         cnt++;
      end while (!out_valid && cnt < 40);
      chk("latency", 64'(cnt), 64'(n));
      chk("result", {32'd0, result}, {32'd0, exp});
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
         chk("hold", {30'd0, out_valid, in_ready, result},
             {30'd0, 1'b1, 1'b0, exp});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("after_accept", {62'd0, out_valid, in_ready}, 64'd1);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      op_a      = '0;
      op_b      = '0;
      abort     = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_outputs",
          {in_ready, out_valid, result, adder_a[29:0]},
          {1'b1, 1'b0, 32'd0, 30'd0});
      chk("rst_adder", {adder_a, adder_b}, 64'd0);
      #12;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      run_op(32'd6, 32'd7, 0);
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0);
      run_op(32'h12345678, 32'd0, 0);
      run_op(32'd3, 32'd5, 5);

      // abort in the 10th RUN cycle of a 32-cycle operation
      issue(32'd9, 32'h80000000);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      chk("abort_pre", {63'd0, out_valid}, 64'd0);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_idle", {30'd0, in_ready, out_valid, result},
          {30'd0, 1'b1, 1'b0, 32'd0});
      run_op(32'd4, 32'd4, 0);

      // asynchronous reset in the middle of RUN
      issue(32'hDEADBEEF, 32'hF0000000);
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst", {30'd0, out_valid, in_ready, result},
          {30'd0, 1'b0, 1'b1, 32'd0});
      #3;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      run_op(32'h0000FFFF, 32'h00010001, 0);

      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         run_op(ra, rb, int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
